// File: rtl/mips_sc_core.sv
// mips_sc_core: single-cycle MIPS32 core (PC, decoder, immediate extender, ALU, write-back select).
module mips_sc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] mem_rd,
    output logic [31:0] pc,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    output logic [4:0]  wa,
    output logic        reg_write,
    output logic [31:0] wd,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        zero
);
    logic [31:0] pc_q, pc_d, pc_plus4, imm_ext, alu_b, alu_y;
    logic [5:0]  opcode, funct;
    logic [3:0]  alu_op;
    logic        reg_dst, rw, ex_top, alu_src, mw, mem2reg, br_eq, br_ne, jump, taken;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        reg_dst = 1'b0;
        rw      = 1'b0;
        ex_top  = 1'b1;
        alu_src = 1'b0;
        alu_op  = 4'b0010;
        mw      = 1'b0;
        mem2reg = 1'b1;
        br_eq   = 1'b0;
        br_ne   = 1'b0;
        jump    = 1'b0;
        case (opcode)
            6'b000000: begin
                reg_dst = 1'b1;
                rw      = 1'b1;
                case (funct)
                    6'b100000: alu_op = 4'b0010;
                    6'b100010: alu_op = 4'b0110;
                    6'b100100: alu_op = 4'b0000;
                    6'b100101: alu_op = 4'b0001;
                    6'b100111: alu_op = 4'b1100;
                    6'b101010: alu_op = 4'b0111;
                    default:   rw     = 1'b0;
                endcase
            end
            6'b001000: begin rw = 1'b1; alu_src = 1'b1; end
            6'b001010: begin rw = 1'b1; alu_src = 1'b1; alu_op = 4'b0111; end
            6'b001100: begin rw = 1'b1; alu_src = 1'b1; alu_op = 4'b0000; ex_top = 1'b0; end
            6'b001101: begin rw = 1'b1; alu_src = 1'b1; alu_op = 4'b0001; ex_top = 1'b0; end
            6'b100011: begin rw = 1'b1; alu_src = 1'b1; mem2reg = 1'b0; end
            6'b101011: begin mw = 1'b1; alu_src = 1'b1; end
            6'b000100: begin br_eq = 1'b1; alu_op = 4'b0110; end
            6'b000101: begin br_ne = 1'b1; alu_op = 4'b0110; end
            6'b000010: jump = 1'b1;
            default:   ;
        endcase
    end

    assign imm_ext = ex_top ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
    assign alu_b   = alu_src ? imm_ext : rd2;

    always_comb begin
        case (alu_op)
            4'b0000: alu_y = rd1 & alu_b;
            4'b0001: alu_y = rd1 | alu_b;
            4'b0010: alu_y = rd1 + alu_b;
            4'b0110: alu_y = rd1 - alu_b;
            4'b0111: alu_y = {31'b0, $signed(rd1) < $signed(alu_b)};
            4'b1100: alu_y = ~(rd1 | alu_b);
            default: alu_y = 32'h0;
        endcase
    end

    assign zero     = (alu_y == 32'h0);
    assign taken    = (br_eq & zero) | (br_ne & ~zero);
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_d     = jump  ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                      taken ? pc_plus4 + (imm_ext << 2) : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // Write enables are gated so a reset landing mid-cycle kills the in-flight instruction.
    assign pc        = pc_q;
    assign ra1       = instr[25:21];
    assign ra2       = instr[20:16];
    assign wa        = reg_dst ? instr[15:11] : instr[20:16];
    assign reg_write = rw & rst_n;
    assign mem_write = mw & rst_n;
    assign wd        = mem2reg ? alu_y : mem_rd;
    assign mem_addr  = alu_y;
    assign mem_wd    = rd2;
endmodule

// File: tb/tb_mips_sc_core.sv
// tb_mips_sc_core: directed vectors with a queue scoreboard checked at the falling clock edge.
module tb_mips_sc_core;
    logic        clk, rst_n;
    logic [31:0] instr, rd1, rd2, mem_rd;
    logic [31:0] pc, wd, mem_addr, mem_wd;
    logic [4:0]  ra1, ra2, wa;
    logic        reg_write, mem_write, zero;

    typedef struct {
        logic [31:0] pc, wd, addr, mwd;
        logic [4:0]  wa;
        logic        rw, mw, z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    mips_sc_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .rd1(rd1), .rd2(rd2), .mem_rd(mem_rd),
        .pc(pc), .ra1(ra1), .ra2(ra2), .wa(wa), .reg_write(reg_write), .wd(wd),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] p, input logic [4:0] a, input logic [31:0] w,
                                input logic r, input logic m, input logic [31:0] ad,
                                input logic z, input logic [31:0] d);
        exp_t e;
        e.pc = p; e.wa = a; e.wd = w; e.rw = r; e.mw = m; e.addr = ad; e.z = z; e.mwd = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic rst, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] m, input exp_t e);
        @(posedge clk);
        #1;
        rst_n = rst; instr = i; rd1 = a; rd2 = b; mem_rd = m;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("wa", {27'b0, wa}, {27'b0, e.wa});
            chk("wd", wd, e.wd);
            chk("reg_write", {31'b0, reg_write}, {31'b0, e.rw});
            chk("mem_write", {31'b0, mem_write}, {31'b0, e.mw});
            chk("mem_addr", mem_addr, e.addr);
            chk("zero", {31'b0, zero}, {31'b0, e.z});
            chk("mem_wd", mem_wd, e.mwd);
        end
    end

    initial begin
        rst_n = 1'b0; instr = 32'h0; rd1 = 32'h0; rd2 = 32'h0; mem_rd = 32'h0;
        issue(1, 32'h0, 0, 0, 0, mk(32'h00, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0, 0, 0, 0, mk(32'h04, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0, 0, 0, 0, mk(32'h08, 0, 0, 0, 0, 0, 1, 0));
        // reset drops mid-cycle while an add is in flight
        issue(1, 32'h0022_1820, 5, 7, 0, mk(32'h00, 3, 12, 0, 0, 12, 0, 7));
        #2 rst_n = 1'b0;
        issue(1, 32'h0, 0, 0, 0, mk(32'h00, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0, 0, 0, 0, mk(32'h04, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0, 0, 0, 0, mk(32'h08, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0022_1820, 5, 7, 0, mk(32'h0C, 3, 12, 1, 0, 12, 0, 7));
        issue(1, 32'h0022_1822, 9, 9, 0, mk(32'h10, 3, 0, 1, 0, 0, 1, 9));
        issue(1, 32'h3422_8000, 0, 32'h55, 0, mk(32'h14, 2, 32'h8000, 1, 0, 32'h8000, 0, 32'h55));
        issue(1, 32'h2022_FFFF, 0, 0, 0, mk(32'h18, 2, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 0));
        issue(1, 32'h8C24_0008, 32'h10, 0, 32'hDEAD_BEEF, mk(32'h1C, 4, 32'hDEAD_BEEF, 1, 0, 32'h18, 0, 0));
        issue(1, 32'hAC24_FFFC, 32'h10, 32'h1234_5678, 32'h0C, mk(32'h20, 4, 32'h0C, 0, 1, 32'h0C, 0, 32'h1234_5678));
        issue(1, 32'h0800_0008, 0, 0, 0, mk(32'h24, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h1022_0003, 7, 7, 0, mk(32'h20, 2, 0, 0, 0, 0, 1, 7));
        issue(1, 32'h0800_0008, 0, 0, 0, mk(32'h30, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h1022_0003, 7, 5, 2, mk(32'h20, 2, 2, 0, 0, 2, 0, 5));
        issue(1, 32'h0800_0008, 0, 0, 0, mk(32'h24, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h1422_0003, 7, 5, 2, mk(32'h20, 2, 2, 0, 0, 2, 0, 5));
        issue(1, 32'h0800_0008, 0, 0, 0, mk(32'h30, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h1422_0003, 7, 7, 0, mk(32'h20, 2, 0, 0, 0, 0, 1, 7));
        issue(1, 32'h0800_0010, 0, 0, 0, mk(32'h24, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0022_182A, 32'hFFFF_FFFF, 1, 0, mk(32'h40, 3, 1, 1, 0, 1, 0, 1));
        issue(1, 32'hFC00_0000, 0, 0, 0, mk(32'h44, 0, 0, 0, 0, 0, 1, 0));
        issue(1, 32'h0, 0, 0, 0, mk(32'h48, 0, 0, 0, 0, 0, 1, 0));
        repeat (2) @(negedge clk);
        #1;
        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_sc_core.md
# mips_sc_core

Single-cycle MIPS32 execution core: program counter register with PC+4 adder and branch/jump target logic, main/ALU control decoder, immediate extender, 32-bit ALU and write-back select. It sits between the external instruction memory, register bank and data memory; those three are outside this block and are driven from its ports. One instruction completes per `clk` cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC value loaded by reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  current instruction from instruction memory (addressed by `pc[7:0]`).
- `rd1`  in  32  register bank read data for `ra1`.
- `rd2`  in  32  register bank read data for `ra2`.
- `mem_rd`  in  32  data memory read data at `mem_addr`.
- `pc`  out  32  current PC.
- `ra1`  out  5  `instr[25:21]` (rs).
- `ra2`  out  5  `instr[20:16]` (rt).
- `wa`  out  5  write register: `instr[15:11]` (rd) if reg_dst, else rt.
- `reg_write`  out  1  register bank write enable.
- `wd`  out  32  register write data.
- `mem_write`  out  1  data memory write enable.
- `mem_addr`  out  32  ALU result.
- `mem_wd`  out  32  equals `rd2`.
- `zero`  out  1  ALU result == 0.

## Operation
- Decode on `opcode=instr[31:26]`, `funct=instr[5:0]`. Internal controls: reg_dst, reg_write, ex_top (1 sign-, 0 zero-extend), alu_src (1 immediate), alu_op[3:0], mem_write, mem2reg (0 selects `mem_rd`, 1 selects ALU result), branch_eq, branch_ne, jump.
- alu_op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (signed, result 1/0), NOR 1100. Any other code yields 0.
- R-type (opcode 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; reg_dst=1, reg_write=1, mem2reg=1. Other funct: no write (NOP).
- addi 001000 ADD sext; slti 001010 SLT sext; andi 001100 AND zext; ori 001101 OR zext. All: alu_src=1, reg_dst=0, reg_write=1, mem2reg=1.
- lw 100011: ADD sext, reg_write=1, mem2reg=0, reg_dst=0. sw 101011: ADD sext, mem_write=1, reg_write=0.
- beq 000100 / bne 000101: SUB on rd1,rd2, no writes; taken when zero=1 / zero=0.
- j 000010: no writes; target = {pc_plus4[31:28], instr[25:0], 2'b00}.
- Undefined opcode: reg_write=0, mem_write=0, PC advances by 4.
- Arithmetic is modulo 2^32; overflow ignored, no exception.
- pc_next priority: jump target; else taken branch → pc_plus4 + (sext(imm) << 2); else pc_plus4 = pc + 4.

## Timing
- `pc` registered, updated on rising `clk`; all other outputs combinational from `instr`, `rd1`, `rd2`, `mem_rd`, `pc`.
- `rst_n` low: `pc` = RESET_PC immediately (asynchronous); `reg_write` and `mem_write` forced 0 while low. First edge after deassertion loads RESET_PC+4 (or branch/jump target of instruction at RESET_PC).
- Register bank and data memory sample `wa/wd/reg_write` and `mem_addr/mem_wd/mem_write` on the same edge that advances `pc`.
- PC wraps 32'hFFFF_FFFC + 4 → 0.
- Reset asserted mid-cycle discards the in-flight instruction; no write occurs for it.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle → pc=0, reg_write=0, mem_write=0; release, 3 NOP edges → pc=0x0C.
- add $3,$1,$2 (0x00221820), rd1=5, rd2=7 → wa=3, wd=12, reg_write=1, zero=0; sub with rd1=rd2=9 → wd=0, zero=1.
- ori $2,$1,0x8000 with rd1=0 → wd=0x0000_8000 (zero-extend); addi $2,$1,-1 with rd1=0 → wd=0xFFFF_FFFF.
- lw $4,8($1), rd1=0x10, mem_rd=0xDEAD_BEEF → mem_addr=0x18, wa=4, wd=0xDEAD_BEEF, mem_write=0; sw $4,-4($1) → mem_addr=0x0C, mem_write=1, mem_wd=rd2, reg_write=0.
- At pc=0x20: beq imm=3, rd1=rd2 → next pc=0x30; rd1≠rd2 → 0x24; bne inverse; j 0x10 → next pc=0x40.
- slt with rd1=0xFFFF_FFFF, rd2=1 → wd=1; undefined opcode 111111 → no writes, pc+4.
